// File: rtl/pll_sup_pkg.sv
// Shared types and constants for the PLL lock supervisor.
// Latency: n/a (declarations and elaboration-time helpers only).
// Backpressure: n/a.
package pll_sup_pkg;

  localparam int LOL_CNT_W = 8;
  localparam int RETRY_W   = 2;
  localparam int STATE_W   = 3;

  // Encodings are exported on state_o and read by firmware status registers.
  typedef enum logic [STATE_W-1:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_FILTER    = 3'd2,
    ST_LOCKED    = 3'd3,
    ST_FAILED    = 3'd4
  } pll_state_e;

  // Ceiling log2. sup_clog2(n + 1) is the bit count needed to hold n.
  function automatic int sup_clog2(input int unsigned value);
    int          result;
    int unsigned v;
    result = 0;
    v      = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

  function automatic int unsigned sup_max3(input int unsigned a,
                                           input int unsigned b,
                                           input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for slow level signals crossing into the local clock.
// Latency: 2 clk cycles from d to q.
// Backpressure: none; levels are sampled every cycle.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // First stage may go metastable; second stage gives it a full cycle to settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, qualifies lock, retries on timeout and reports readiness.
// Latency: pll_locked reaches the FSM after 2 refclk; all outputs registered off next state.
// Backpressure: none; relock_req is a one-cycle request that always wins.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 125000,
  parameter int LOCK_FILTER_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 3,
  parameter int CNT_W               = 17
) (
  input  logic                 refclk,
  input  logic                 rst_n,
  input  logic                 pll_locked,
  input  logic                 relock_req,
  output logic                 pll_rst,
  output logic                 pll_ready,
  output logic                 lol_pulse,
  output logic [LOL_CNT_W-1:0] lol_count,
  output logic [RETRY_W-1:0]   retry_count,
  output logic                 fail,
  output logic [STATE_W-1:0]   state_o
);

  localparam int CNT_W_MIN = sup_clog2(sup_max3(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES,
                                                LOCK_FILTER_CYCLES) + 1);

  // Reject parameter sets the shared counter or retry field cannot represent.
  if (CNT_W < CNT_W_MIN || RST_PULSE_CYCLES < 1 || LOCK_TIMEOUT_CYCLES < 1 ||
      LOCK_FILTER_CYCLES < 1 || MAX_RETRIES < 0 || MAX_RETRIES > (1 << RETRY_W) - 1)
  begin : g_param_check
    $error("pll_lock_supervisor: illegal parameter combination");
  end

  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   FILTER_LAST  = CNT_W'(LOCK_FILTER_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

  pll_state_e         state_q;
  pll_state_e         state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [RETRY_W-1:0] retry_d;
  logic               lol_evt;
  logic               lk_s;

  // pll_locked comes from the PLL's own clock domain; never use it raw.
  sync_2ff #(
    .WIDTH (1)
  ) u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lk_s)
  );

  // Next-state, shared counter and retry bookkeeping; relock_req overrides everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_count;
    lol_evt = 1'b0;
    if (relock_req) begin
      state_d = ST_RESET_PLL;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_RESET_PLL: begin
          if (cnt_q == RST_LAST) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          if (lk_s) begin
            state_d = ST_FILTER;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            cnt_d = '0;
            if (retry_count < RETRY_MAX) begin
              retry_d = retry_count + 1'b1;
              state_d = ST_RESET_PLL;
            end else begin
              state_d = ST_FAILED;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_FILTER: begin
          // A lock glitch restarts the timeout window but does not burn a retry.
          if (!lk_s) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == FILTER_LAST) begin
            state_d = ST_LOCKED;
            cnt_d   = '0;
            retry_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_LOCKED: begin
          if (!lk_s) begin
            state_d = ST_RESET_PLL;
            cnt_d   = '0;
            lol_evt = 1'b1;
          end
        end
        ST_FAILED: begin
          state_d = ST_FAILED;
        end
        default: begin
          state_d = ST_RESET_PLL;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and cycle counter registers.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RESET_PLL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode the next state so they change on the same edge as the state register.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      pll_rst   <= 1'b1;
      pll_ready <= 1'b0;
      fail      <= 1'b0;
      lol_pulse <= 1'b0;
    end else begin
      pll_rst   <= (state_d == ST_RESET_PLL) || (state_d == ST_FAILED);
      pll_ready <= (state_d == ST_LOCKED);
      fail      <= (state_d == ST_FAILED);
      lol_pulse <= lol_evt;
    end
  end

  // Retry count follows the FSM; loss-of-lock count saturates and only rst_n clears it.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      retry_count <= '0;
      lol_count   <= '0;
    end else begin
      retry_count <= retry_d;
      if (lol_evt && (lol_count != {LOL_CNT_W{1'b1}})) begin
        lol_count <= lol_count + 1'b1;
      end
    end
  end

  assign state_o = state_q;

endmodule
